// File: rtl/wls_pkg.sv
// Shared types and defaults for the weight-load sequencer.
package wls_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WAIT_ACK,
    FIN
  } state_t;

  localparam int DRAIN_CYCLES = 2;
  localparam int ROWS_DEF     = 4;
  localparam int AW_DEF       = 10;
  localparam int DW_DEF       = 32;

endpackage

// File: rtl/wls_addr_gen.sv
// Row/tile counters and wrapping SRAM address (base + tile*ROWS + row).
module wls_addr_gen #(
  parameter int ROWS = 4,
  parameter int AW   = 10,
  parameter int RW   = 2
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          clr,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [7:0]    ntiles,
  output logic          row_last,
  output logic          tile_last,
  output logic [RW-1:0] row,
  output logic [AW-1:0] addr
);

  logic [RW-1:0] row_q, row_d;
  logic [7:0]    tile_q, tile_d;

  assign row_last  = (row_q == RW'(ROWS - 1));
  assign tile_last = (tile_q == ntiles - 8'd1);
  assign row       = row_q;
  // Sum is held to AW bits, so addresses wrap modulo 2^AW.
  assign addr      = base + AW'(tile_q) * AW'(ROWS) + AW'(row_q);

  always_comb begin
    row_d  = row_q;
    tile_d = tile_q;
    if (clr) begin
      row_d  = '0;
      tile_d = '0;
    end else if (step) begin
      if (row_last) begin
        row_d  = '0;
        tile_d = tile_q + 8'd1;
      end else begin
        row_d = row_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      row_q  <= '0;
      tile_q <= '0;
    end else begin
      row_q  <= row_d;
      tile_q <= tile_d;
    end
  end

endmodule

// File: rtl/weight_load_seq.sv
// Streams weight tiles from SRAM onto the MAC-array weight-load bus, one row per cycle.
// Optional ABORT input is built in when WLS_ABORT_EN is defined.
module weight_load_seq
  import wls_pkg::*;
#(
  parameter int  ROWS = ROWS_DEF,
  parameter int  AW   = AW_DEF,
  parameter int  DW   = DW_DEF,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [AW-1:0] BASE_ADDR,
  input  logic [7:0]    NTILES,
  input  logic [4:0]    SHAMT,
  input  logic          TILE_ACK,
`ifdef WLS_ABORT_EN
  input  logic          ABORT,
`endif
  output logic          MEM_RE,
  output logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          WLoad1,
  output logic [DW-1:0] WDATA1,
  output logic [4:0]    shamt1,
  output logic [RW-1:0] WROW1,
  output logic          BUSY,
  output logic          DONE
);

  state_t        state_q, state_d;
  logic [1:0]    drain_q, drain_d;
  logic          more_q, more_d;
  logic [AW-1:0] base_q, base_d;
  logic [7:0]    ntiles_q, ntiles_d;
  logic [4:0]    job_shamt_q, job_shamt_d;
  logic          mem_re_q, mem_re_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rv_q, rv_d;
  logic [RW-1:0] rtag_q, rtag_d;
  logic          wload_q, wload_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [4:0]    shamt_q, shamt_d;
  logic [RW-1:0] wrow_q, wrow_d;

  logic          ag_clr, ag_step, row_last, tile_last;
  logic [RW-1:0] cur_row;
  logic [AW-1:0] cur_addr;
  logic          abort_w, abort_hit;

`ifdef WLS_ABORT_EN
  assign abort_w = ABORT;
`else
  assign abort_w = 1'b0;
`endif
  assign abort_hit = abort_w && (state_q != IDLE);

  wls_addr_gen #(.ROWS(ROWS), .AW(AW), .RW(RW)) u_addr_gen (
    .clk      (CLK),
    .srst     (RST),
    .clr      (ag_clr),
    .step     (ag_step),
    .base     (base_q),
    .ntiles   (ntiles_q),
    .row_last (row_last),
    .tile_last(tile_last),
    .row      (cur_row),
    .addr     (cur_addr)
  );

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    more_d      = more_q;
    base_d      = base_q;
    ntiles_d    = ntiles_q;
    job_shamt_d = job_shamt_q;
    ag_clr      = 1'b0;
    ag_step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          base_d      = BASE_ADDR;
          ntiles_d    = NTILES;
          job_shamt_d = SHAMT;
          ag_clr      = 1'b1;
          state_d     = (NTILES != 8'd0) ? FETCH : FIN;
        end
      end
      FETCH: begin
        ag_step = 1'b1;
        if (row_last) begin
          state_d = DRAIN;
          drain_d = '0;
          more_d  = !tile_last;
        end
      end
      DRAIN: begin
        // Hold until the final read of the tile has reached the bus.
        if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
          state_d = more_q ? WAIT_ACK : FIN;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      WAIT_ACK: begin
        if (TILE_ACK) state_d = FETCH;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      ag_clr  = 1'b1;
    end
  end

  always_comb begin
    mem_re_d = (state_d == FETCH);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == FIN);
    rv_d     = mem_re_q && !abort_hit;
    rtag_d   = cur_row;
    wload_d  = rv_q && !abort_hit;
    wdata_d  = wload_d ? MEM_RDATA : '0;
    wrow_d   = wload_d ? rtag_q : '0;
    shamt_d  = wload_d ? job_shamt_q : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      drain_q     <= '0;
      more_q      <= 1'b0;
      base_q      <= '0;
      ntiles_q    <= '0;
      job_shamt_q <= '0;
      mem_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rv_q        <= 1'b0;
      rtag_q      <= '0;
      wload_q     <= 1'b0;
      wdata_q     <= '0;
      shamt_q     <= '0;
      wrow_q      <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      more_q      <= more_d;
      base_q      <= base_d;
      ntiles_q    <= ntiles_d;
      job_shamt_q <= job_shamt_d;
      mem_re_q    <= mem_re_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rv_q        <= rv_d;
      rtag_q      <= rtag_d;
      wload_q     <= wload_d;
      wdata_q     <= wdata_d;
      shamt_q     <= shamt_d;
      wrow_q      <= wrow_d;
    end
  end

  assign MEM_RE   = mem_re_q;
  assign MEM_ADDR = mem_re_q ? cur_addr : '0;
  assign WLoad1   = wload_q;
  assign WDATA1   = wdata_q;
  assign shamt1   = shamt_q;
  assign WROW1    = wrow_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_weight_load_seq.sv
// Directed plus randomized checks of weight_load_seq against a tile-level timing/data model.
module tb_weight_load_seq;

  localparam int ROWS = 4;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int RW   = 2;

  logic          CLK = 1'b0;
  logic          RST, START, TILE_ACK;
  logic [AW-1:0] BASE_ADDR;
  logic [7:0]    NTILES;
  logic [4:0]    SHAMT;
  logic          MEM_RE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_RDATA;
  logic          WLoad1;
  logic [DW-1:0] WDATA1;
  logic [4:0]    shamt1;
  logic [RW-1:0] WROW1;
  logic          BUSY, DONE;
`ifdef WLS_ABORT_EN
  logic          ABORT;
`endif

  weight_load_seq #(.ROWS(ROWS), .AW(AW), .DW(DW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .BASE_ADDR(BASE_ADDR),
    .NTILES   (NTILES),
    .SHAMT    (SHAMT),
    .TILE_ACK (TILE_ACK),
`ifdef WLS_ABORT_EN
    .ABORT    (ABORT),
`endif
    .MEM_RE   (MEM_RE),
    .MEM_ADDR (MEM_ADDR),
    .MEM_RDATA(MEM_RDATA),
    .WLoad1   (WLoad1),
    .WDATA1   (WDATA1),
    .shamt1   (shamt1),
    .WROW1    (WROW1),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  // SRAM model: read data appears exactly one cycle after MEM_RE.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge CLK) MEM_RDATA <= MEM_RE ? sram[MEM_ADDR] : {DW{1'bx}};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            row;
    int            sh;
    int            c;
  } beat_t;

  bit            logging = 1'b0;
  int            cyc0;
  logic [AW-1:0] rd_addr [$];
  int            rd_cyc  [$];
  beat_t         beats   [$];
  int            done_cyc[$];
  int            idle_viol, busy_rise, busy_fall;
  bit            busy_prev;

  always @(negedge CLK) begin : mon
    int    rel;
    beat_t b;
    if (logging) begin
      rel = cyc - cyc0;
      if (MEM_RE) begin
        rd_addr.push_back(MEM_ADDR);
        rd_cyc.push_back(rel);
      end
      if (WLoad1) begin
        b.data = WDATA1; b.row = int'(WROW1); b.sh = int'(shamt1); b.c = rel;
        beats.push_back(b);
      end else if (shamt1 != 5'd0) begin
        idle_viol = idle_viol + 1;
      end
      if (DONE) done_cyc.push_back(rel);
      if (BUSY && !busy_prev && busy_rise < 0) busy_rise = rel;
      if (!BUSY && busy_prev && busy_fall < 0) busy_fall = rel;
      busy_prev = BUSY;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check(tag, {MEM_RE, MEM_ADDR, WLoad1, WDATA1, shamt1, WROW1, BUSY, DONE}, 64'd0);
  endtask

  // One job: model predicts every read, beat and DONE by cycle relative to START.
  task automatic run_job(input string name, input logic [AW-1:0] base, input int ntiles,
                         input logic [4:0] shamt, input int ack_dly, input bit noise);
    logic [AW-1:0] e_addr[$];
    int            e_rcyc[$];
    beat_t         e_beat[$];
    int            ack_at[$];
    beat_t         b;
    int            f, a, done_rel, n;
    f = 1;
    done_rel = 1;
    for (int t = 0; t < ntiles; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        a = (int'(base) + t * ROWS + r) % (1 << AW);
        e_addr.push_back(AW'(a));
        e_rcyc.push_back(f + r);
        b.data = sram[a]; b.row = r; b.sh = int'(shamt); b.c = f + r + 2;
        e_beat.push_back(b);
      end
      if (t == ntiles - 1) done_rel = f + ROWS + 2;
      else begin
        ack_at.push_back(f + ROWS + 2 + ack_dly);
        f = f + ROWS + 2 + ack_dly + 1;
      end
    end
    rd_addr.delete(); rd_cyc.delete(); beats.delete(); done_cyc.delete();
    idle_viol = 0; busy_rise = -1; busy_fall = -1; busy_prev = 1'b0;

    @(posedge CLK); #1;
    START = 1'b1; BASE_ADDR = base; NTILES = 8'(ntiles); SHAMT = shamt;
    cyc0 = cyc; logging = 1'b1;
    for (int rel = 1; rel <= done_rel + 3; rel++) begin
      @(posedge CLK); #1;
      START    = noise && (rel == 2);
      TILE_ACK = noise && (rel == 2);
      if (noise && rel == 2) begin
        BASE_ADDR = ~base; NTILES = 8'd7; SHAMT = ~shamt;
      end
      foreach (ack_at[i]) if (ack_at[i] == rel) TILE_ACK = 1'b1;
    end
    @(negedge CLK); #1;
    logging = 1'b0; START = 1'b0; TILE_ACK = 1'b0;

    check({name, " nreads"}, rd_addr.size(), e_addr.size());
    n = (rd_addr.size() < e_addr.size()) ? rd_addr.size() : e_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s rd%0d addr", name, i), rd_addr[i], e_addr[i]);
      check($sformatf("%s rd%0d cyc", name, i), rd_cyc[i], e_rcyc[i]);
    end
    check({name, " nbeats"}, beats.size(), e_beat.size());
    n = (beats.size() < e_beat.size()) ? beats.size() : e_beat.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s bt%0d data", name, i), beats[i].data, e_beat[i].data);
      check($sformatf("%s bt%0d row", name, i), beats[i].row, e_beat[i].row);
      check($sformatf("%s bt%0d shamt", name, i), beats[i].sh, e_beat[i].sh);
      check($sformatf("%s bt%0d cyc", name, i), beats[i].c, e_beat[i].c);
    end
    check({name, " ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) check({name, " done cyc"}, done_cyc[0], done_rel);
    check({name, " busy rise"}, busy_rise, 1);
    check({name, " busy fall"}, busy_fall, done_rel + 1);
    check({name, " idle shamt"}, idle_viol, 0);
    $display("job %s base=%0h ntiles=%0d shamt=%0d reads=%0d beats=%0d", name, base,
             ntiles, shamt, rd_addr.size(), beats.size());
  endtask

  // Interrupt a two-tile job at cycle 4 with RST (mode 0) or ABORT (mode 1).
  task automatic cut_job(input string name, input int mode);
    int n_done, n_re;
    @(posedge CLK); #1;
    START = 1'b1; BASE_ADDR = 10'h100; NTILES = 8'd2; SHAMT = 5'd9;
    for (int rel = 1; rel <= 4; rel++) begin
      @(posedge CLK); #1;
      START = 1'b0;
    end
    if (mode == 0) RST = 1'b1;
`ifdef WLS_ABORT_EN
    else ABORT = 1'b1;
`endif
    @(posedge CLK); #1;
    RST = 1'b0;
`ifdef WLS_ABORT_EN
    ABORT = 1'b0;
`endif
    @(negedge CLK);
    outputs_zero({name, " outputs next cycle"});
    n_done = 0; n_re = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (DONE) n_done++;
      if (MEM_RE || WLoad1) n_re++;
    end
    check({name, " no done"}, n_done, 0);
    check({name, " no activity"}, n_re, 0);
    $display("job %s cut at cycle 4 done=%0d active=%0d", name, n_done, n_re);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; TILE_ACK = 1'b0;
    BASE_ADDR = '0; NTILES = '0; SHAMT = '0;
`ifdef WLS_ABORT_EN
    ABORT = 1'b0;
`endif
    for (int i = 0; i < (1 << AW); i++) sram[i] = $urandom;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    outputs_zero("reset state");
    #1 RST = 1'b0;
    @(negedge CLK);
    outputs_zero("after reset release");

    run_job("single", 10'h010, 1, 5'd7, 0, 1'b0);
    run_job("two_tiles", 10'h010, 2, 5'd3, 5, 1'b0);
    run_job("wrap", 10'h3FE, 1, 5'd31, 0, 1'b0);
    run_job("ignored", 10'h040, 1, 5'd12, 0, 1'b1);
    run_job("zero", 10'h020, 0, 5'd5, 0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      run_job($sformatf("rand%0d", j), AW'($urandom), int'($urandom_range(1, 3)),
              5'($urandom), int'($urandom_range(0, 4)), 1'b0);
    end
    cut_job("reset_mid", 0);
`ifdef WLS_ABORT_EN
    cut_job("abort_mid", 1);
`endif
    run_job("after_cut", 10'h200, 1, 5'd1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_load_seq.md
# weight_load_seq

Sequencer that fetches weight tiles from the on-chip weight SRAM and drives the MAC-array weight-load bus (WLoad1/WDATA1/shamt1/WROW1) one row per cycle. It sits upstream of the weight-load pipeline register stage and is the producer end of that bus. A tile is ROWS consecutive 32-bit words. Between tiles, the sequencer waits for the array's tile acknowledge before streaming the next tile.

## Interface
Parameters:
- ROWS, 4: rows per tile; WROW1 width is clog2(ROWS).
- AW, 10: weight SRAM address width.
- DW, 32: weight word width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle request; sampled only in IDLE.
- BASE_ADDR  in  AW  first word address; latched on START.
- NTILES  in  8  tile count; latched on START.
- SHAMT  in  5  per-job shift amount; latched on START.
- TILE_ACK  in  1  array has consumed the current tile; honoured only in WAIT_ACK.
- MEM_RE  out  1  SRAM read enable.
- MEM_ADDR  out  AW  SRAM read address.
- MEM_RDATA  in  DW  SRAM read data, valid exactly 1 cycle after MEM_RE.
- WLoad1  out  1  weight row valid.
- WDATA1  out  DW  weight row data.
- shamt1  out  5  latched SHAMT while WLoad1=1, else 0.
- WROW1  out  clog2(ROWS)  row index within tile.
- BUSY  out  1  state != IDLE.
- DONE  out  1  one-cycle job-complete pulse.
- ABORT  in  1  present only with WLS_ABORT_EN.

## Operation
- States: IDLE, FETCH, DRAIN, WAIT_ACK, FIN.
- **IDLE**
  - On START with NTILES!=0: latch inputs, go to FETCH.
  - On START with NTILES==0: go to FIN; no reads are issued.
- **FETCH**
  - ROWS cycles. MEM_RE=1, MEM_ADDR = BASE + tile*ROWS + row.
  - Address wraps modulo 2^AW.
  - After row ROWS-1, go to DRAIN.
- **DRAIN**
  - 2 cycles, so the last read data reaches WLoad1.
  - Then, if tiles remain, go to WAIT_ACK; otherwise go to FIN.
- **WAIT_ACK**
  - Stay until TILE_ACK=1, then go to FETCH for the next tile with row=0.
- **FIN**
  - DONE=1 for one cycle, then go to IDLE.
- Data path
  - The read-valid flag is MEM_RE delayed 1 cycle, tagged with its row index.
  - WLoad1/WDATA1/WROW1/shamt1 are registered from that flag, MEM_RDATA and the tag.
- Ignored inputs
  - START outside IDLE is ignored.
  - TILE_ACK outside WAIT_ACK is ignored and is not remembered.
- Reset values: every output 0, state IDLE, counters 0.
- Reset mid-job: all outputs are 0 at the next edge; in-flight read data is discarded; no DONE is produced.

## Timing
- START high at cycle 0.
- MEM_RE high in cycles 1..ROWS.
- MEM_RDATA valid in cycles 2..ROWS+1.
- WLoad1 high in cycles 3..ROWS+2, with WROW1 = 0..ROWS-1 contiguous.
- BUSY rises in cycle 1.
- Single tile, ROWS=4: DRAIN is cycles 5–6, DONE is in cycle 7, BUSY falls in cycle 8.
- WAIT_ACK is entered at cycle ROWS+3. TILE_ACK sampled high in cycle k gives MEM_RE in cycle k+1.
- Throughput is 1 row/cycle within a tile.
- Minimum inter-tile gap is 3 idle WLoad1 cycles plus the ACK latency.

## Configuration
- WLS_ABORT_EN defined:
  - The ABORT port exists.
  - ABORT=1 in any non-IDLE state forces IDLE at the next edge.
  - MEM_RE and WLoad1 drop at that edge; in-flight read data is dropped.
  - No DONE is produced; ABORT has priority over TILE_ACK.
- Undefined: the port is absent and a job always runs to FIN.

## Structure
- Package wls_pkg holds:
  - the state enum (IDLE, FETCH, DRAIN, WAIT_ACK, FIN);
  - DRAIN_CYCLES=2;
  - the default ROWS/AW/DW localparams.
- Sub-module wls_addr_gen holds the row and tile counters and the wrapping address adder (BASE + tile*ROWS + row). Its interface is clr, step, row_last, tile_last and addr.

## Test plan
- **Single tile.** BASE=0x010, NTILES=1, SHAMT=7, SRAM[0x10..0x13]=A0..A3.
  - WLoad1 cycles 3–6 carry WDATA1 A0..A3, WROW1 0..3, shamt1=7.
  - DONE in cycle 7.
- **Two tiles.** NTILES=2, TILE_ACK held low for 5 cycles in WAIT_ACK, then pulsed.
  - No MEM_RE during the wait.
  - Second tile reads 0x14..0x17 starting the cycle after the ACK.
  - Exactly 8 WLoad1 beats; one DONE.
- **Wrap.** BASE=0x3FE, AW=10, NTILES=1 → MEM_ADDR sequence 0x3FE, 0x3FF, 0x000, 0x001.
- **Ignored inputs.** START during FETCH and TILE_ACK during FETCH are both ignored. The job is unchanged and there is no extra tile.
- **Zero tiles.** NTILES=0 → no MEM_RE, no WLoad1, DONE in cycle 1.
- **Reset and abort.**
  - RST asserted at cycle 4 of a job: all outputs 0 the next cycle, no DONE.
  - With WLS_ABORT_EN, ABORT at cycle 4 gives the same behaviour.
